// File: rtl/softstart_seq.sv
// Soft-start sequencer: precharge hold, stepped reference ramp, power-good.
// Optional soft-stop ramp-down enabled by SOFTSTART_SOFTSTOP_EN.
module softstart_seq #(
    parameter int CODE_W  = 8,
    parameter int PRE_CYC = 16,
    parameter int DIV_W   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    input  logic              en,
    input  logic              fault,
    input  logic [DIV_W-1:0]  step_div,
    output logic [CODE_W-1:0] ss_code,
    output logic              drv_en,
    output logic              pgood,
    output logic              busy
);
    localparam int PRE_W = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_CYC - 1);
    localparam logic [CODE_W-1:0] LAST = {{(CODE_W-1){1'b1}}, 1'b0};
    localparam logic [CODE_W-1:0] ONE = {{(CODE_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRECHG = 3'd1,
        RAMP   = 3'd2,
        ON     = 3'd3,
`ifdef SOFTSTART_SOFTSTOP_EN
        STOP   = 3'd5,
`endif
        FAULT  = 3'd4
    } state_t;

    state_t            state_q;
    logic [PRE_W-1:0]  pre_q;
    logic [DIV_W-1:0]  div_q;
    logic [CODE_W-1:0] ss_code_q;
    logic              drv_en_q;
    logic              pgood_q;
    logic              busy_q;
    logic              step_hit;
    logic              fault_go;
    logic              unused_pins;

    assign unused_pins = CELV ^ CELG ^ SUB;
    // >= so a step_div lowered mid-ramp takes effect on the next edge
    assign step_hit = (div_q >= step_div);
    assign fault_go = fault && (state_q != FAULT) && (state_q != IDLE || en);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            div_q     <= '0;
            ss_code_q <= '0;
            drv_en_q  <= 1'b0;
            pgood_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else if (fault_go) begin
            state_q   <= FAULT;
            pre_q     <= '0;
            div_q     <= '0;
            ss_code_q <= '0;
            drv_en_q  <= 1'b0;
            pgood_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= PRECHG;
                        pre_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                PRECHG: begin
                    if (!en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (pre_q == PRE_LAST) begin
                        state_q  <= RAMP;
                        drv_en_q <= 1'b1;
                        div_q    <= '0;
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
                RAMP, ON: begin
                    if (!en) begin
`ifdef SOFTSTART_SOFTSTOP_EN
                        state_q <= STOP;
                        pgood_q <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= '0;
`else
                        state_q   <= IDLE;
                        ss_code_q <= '0;
                        drv_en_q  <= 1'b0;
                        pgood_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        div_q     <= '0;
`endif
                    end else if (state_q == RAMP) begin
                        if (step_hit) begin
                            div_q     <= '0;
                            ss_code_q <= ss_code_q + 1'b1;
                            if (ss_code_q == LAST) begin
                                state_q <= ON;
                                pgood_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                end
`ifdef SOFTSTART_SOFTSTOP_EN
                STOP: begin
                    if (en) begin
                        state_q <= RAMP;
                        div_q   <= '0;
                    end else if (ss_code_q == '0) begin
                        state_q  <= IDLE;
                        drv_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (step_hit) begin
                        div_q     <= '0;
                        ss_code_q <= ss_code_q - 1'b1;
                        if (ss_code_q == ONE) begin
                            state_q  <= IDLE;
                            drv_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
`endif
                FAULT: begin
                    if (!fault && !en) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ss_code = ss_code_q;
    assign drv_en  = drv_en_q;
    assign pgood   = pgood_q;
    assign busy    = busy_q;

endmodule
